// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master bridge.
// Holds the bridge state encoding, bus widths, PPROT field values and a
// small address-alignment helper.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_SW = APB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'h0,
    ST_SETUP  = 2'h1,
    ST_ACCESS = 2'h2,
    ST_RESP   = 2'h3
  } apb_state_e;

  // PPROT[0]: privileged, PPROT[1]: non-secure, PPROT[2]: instruction
  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  // APB transfers are word aligned; drop the byte offset.
  function automatic logic [APB_AW-1:0] apb_word_addr(input logic [APB_AW-1:0] addr);
    return {addr[APB_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: request/response channel plus APB3 bus signals.
// modport master is the bridge side, modport slave is the requester +
// APB completer side (testbench or glue logic).
interface apb_master_bridge_if;
  import apb_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [APB_AW-1:0] req_addr;
  logic [APB_DW-1:0] req_wdata;
  logic [APB_SW-1:0] req_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [APB_DW-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic [APB_AW-1:0] PADDR;
  logic              PWRITE;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_SW-1:0] PSTRB;
  logic [2:0]        PPROT;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: 16-bit wait-state counter for the ACCESS phase.
// Cleared on entry to ACCESS, counts cycles with PREADY low, saturates
// once it reaches P_LIMIT and flags expiry. Used only with APB_TIMEOUT_EN.
module apb_wait_timer #(
  parameter int unsigned P_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        enable_i,
  output logic [15:0] count_o,
  output logic        expired_o
);

  localparam logic [15:0] LP_LIMIT = 16'(P_LIMIT);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign expired_o = (count_q == LP_LIMIT);
  assign count_o   = count_q;

  // Next count: clear has priority, then increment until the limit is hit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'h0000;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 initiator.
// Turns one valid/ready request into one APB transfer and returns read
// data plus slave error on a held response channel. All APB outputs are
// registered; req_ready is high only in ST_IDLE.
// Optional feature macro: APB_TIMEOUT_EN -- aborts an ACCESS phase that
// stays in wait states for P_TIMEOUT cycles, reporting rsp_err=1.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned P_MST_ID  = 0,
  parameter logic [2:0]  P_PPROT   = 3'b000,
  parameter int unsigned P_TIMEOUT = 256
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  apb_state_e        state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic [APB_AW-1:0] paddr_q,     paddr_d;
  logic              pwrite_q,    pwrite_d;
  logic [APB_DW-1:0] pwdata_q,    pwdata_d;
  logic [APB_SW-1:0] pstrb_q,     pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              expired_s;

`ifdef APB_TIMEOUT_EN
  logic [15:0] wait_count_s;
  logic        timeout_abort_s;

  apb_wait_timer #(
    .P_LIMIT (P_TIMEOUT)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .clear_i   (state_q == ST_SETUP),
    .enable_i  ((state_q == ST_ACCESS) && !bus.PREADY),
    .count_o   (wait_count_s),
    .expired_o (expired_s)
  );

  assign timeout_abort_s = (state_q == ST_ACCESS) && !bus.PREADY && expired_s;

`ifndef SYNTHESIS
  // Report aborted transfers so a hung completer is easy to spot in logs.
  always_ff @(posedge PCLK) begin
    if (timeout_abort_s) begin
      $display("apb_master_bridge[%0d]: timeout after %0d wait cycles, PADDR=0x%08h",
               P_MST_ID, wait_count_s, paddr_q);
    end
  end
`endif
`else
  // Without the timer the bridge waits for PREADY indefinitely.
  assign expired_s = 1'b0;
`endif

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = P_PPROT;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = apb_word_addr(bus.req_addr);
          pwrite_d  = bus.req_write;
          pwdata_d  = bus.req_wdata;
          pstrb_d   = bus.req_write ? bus.req_strb : 4'h0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pstrb_d     = 4'h0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'h0000_0000 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          state_d     = ST_RESP;
        end else if (expired_s) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pstrb_d     = 4'h0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pstrb_d     = 4'h0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= 32'h0000_0000;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0000_0000;
      pstrb_q     <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator. Converts a valid/ready request + response interface into AMBA APB3 transfers, with PSTRB/PPROT driven.
- Used in testbenches and SoC glue to drive APB memories and peripherals, such as the APB memory model with configurable response delay.
- Completes one transfer per request.
- Returns read data and the slave error status on a held response channel.

Parameters:
- P_MST_ID, 0, instance identifier; used in simulation messages only.
- P_PPROT, 3'b000, constant value driven on PPROT.
- P_TIMEOUT, 256, maximum wait-state cycles in ACCESS before abort; active only with APB_TIMEOUT_EN; legal range 1..65535.

Ports:
- PRESETn  in  1  async active-low reset
- PCLK  in  1  clock; all logic on posedge
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_strb  in  4  byte enables (writes)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  PSLVERR or timeout
- PSEL  out  1
- PENABLE  out  1
- PADDR  out  32
- PWRITE  out  1
- PWDATA  out  32
- PSTRB  out  4
- PPROT  out  3  constant P_PPROT
- PRDATA  in  32
- PREADY  in  1
- PSLVERR  in  1

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESETn is asynchronous, active-low.
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 once reset is released.
- All APB outputs are registered. req_ready is combinational: it is high only in ST_IDLE.

State machine (ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP):
- ST_IDLE:
  - On req_valid, latch the request and go to ST_SETUP.
  - Drive PSEL=1, PENABLE=0, PADDR={req_addr[31:2],2'b00}, PWRITE=req_write.
  - Drive PWDATA=req_wdata; PSTRB=req_strb for writes, 4'h0 for reads.
- ST_SETUP: exactly one cycle. PENABLE becomes 1; go to ST_ACCESS.
- ST_ACCESS:
  - Hold PADDR, PWRITE, PWDATA and PSTRB stable.
  - At an edge where PREADY=1: capture PRDATA (reads) or 0 (writes) into rsp_rdata, and PSLVERR into rsp_err.
  - On that same edge, drop PSEL/PENABLE, set rsp_valid=1 and go to ST_RESP.
  - PSLVERR is sampled only at that completing edge.
- ST_RESP:
  - Hold rsp_valid, rsp_rdata and rsp_err until rsp_valid&&rsp_ready.
  - Then clear rsp_valid and go to ST_IDLE.
  - No new request is accepted in this state.

Timing and boundary rules:
- Latency with zero wait states: request accepted at edge N → PSEL at N+1, PENABLE at N+2, rsp_valid at N+3. Each PREADY-low cycle adds one.
- Minimum spacing is 4 cycles per transfer when rsp_ready is tied high.
- After completion, PADDR, PWRITE and PWDATA retain their last values; PSTRB returns to 0.
- req_valid deasserted without acceptance: no effect.
- Back-to-back requests are taken in ST_IDLE only.
- PRESETn asserted in any state: outputs take reset values immediately, the pending transfer is dropped and no response is produced.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ST_ACCESS and increments each ST_ACCESS cycle with PREADY=0.
  - When the count reaches P_TIMEOUT with PREADY still 0, the transfer aborts: PSEL/PENABLE go to 0 at the next edge, rsp_valid=1, rsp_err=1, rsp_rdata=0, next state ST_RESP.
  - In simulation, a `$display` reports P_MST_ID and PADDR.
  - If PREADY=1 on the same edge the count reaches P_TIMEOUT, the transfer completes normally.
- Undefined: no counter is built; the bridge waits indefinitely for PREADY.

Decomposition:
- Package apb_pkg holds:
  - state encodings ST_IDLE=2'h0, ST_SETUP=2'h1, ST_ACCESS=2'h2, ST_RESP=2'h3;
  - APB_AW=32, APB_DW=32;
  - PPROT field constants: privileged, non-secure, instruction.
- Sub-module apb_wait_timer (counter, clear, enable, expired) holds the timeout logic; it is instantiated only under APB_TIMEOUT_EN.
- Everything else stays in one module.

Test Plan:
1. Write addr 0x0000_0013, wdata 0xA5A5_1234, strb 4'hF, PREADY=1 → PADDR=0x0000_0010, PSEL@N+1, PENABLE@N+2, rsp_valid@N+3 with rsp_err=0. A read of 0x10 then returns rsp_rdata=0xA5A5_1234 and PSTRB=0.
2. Read with 3 PREADY-low cycles → PENABLE high for 4 cycles, PADDR/PWRITE unchanged throughout, rsp_valid@N+6.
3. Write with PSLVERR=1 at completion → rsp_err=1, rsp_rdata=0. The next clean read returns rsp_err=0.
4. rsp_ready low for 5 cycles while req_valid stays high → rsp_valid/rsp_rdata held constant, req_ready=0, PSEL stays 0. Handshake on the 6th cycle, then the new request is accepted.
5. PRESETn pulsed low during ST_ACCESS → PSEL/PENABLE/rsp_valid=0 asynchronously. After release: req_ready=1 and no response for the dropped transfer.
6. APB_TIMEOUT_EN, P_TIMEOUT=16, PREADY stuck 0 → abort after 16 wait cycles with rsp_err=1 and rsp_rdata=0. A following zero-wait read completes normally.
